conv_layer_seq: RTL



---
 rtl/cnn_pkg.sv | 19 +
 rtl/conv_layer_seq.sv | 133 +++++++++++++
 2 files changed

// File: rtl/cnn_pkg.sv
// Shared types and widths for the convolution engine control path.
package cnn_pkg;

   // Loop counter width, shared by the layer sequencer and the PE FSM.
   localparam int CNT_W = 8;

   // Width of the PE watchdog counter.
   localparam int WD_W = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WREQ,
      S_PE_GO,
      S_PE_WAIT,
      S_OFM_WR,
      S_FIN
   } conv_seq_state_t;

endpackage

// File: rtl/conv_layer_seq.sv
// Layer-level sequencer: for every output filter, walk every input channel
// (load weights, run one PE plane pass), then write the finished OFM back.
module conv_layer_seq
   import cnn_pkg::*;
#(
   parameter int KERNEL_SIZE = 4,
   parameter int IFM_SIZE    = 9,
   parameter int CI          = 3,
   parameter int CO          = 4,
   parameter int TIMEOUT     = 1023
) (
   input  logic             clk1,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             wgt_req,
   input  logic             wgt_ack,
   output logic [CNT_W-1:0] wgt_ch,
   output logic [CNT_W-1:0] wgt_filt,
   output logic             pe_start,
   input  logic             pe_done,
   output logic             psum_clr,
   output logic             psum_last,
   output logic [7:0]       pe_ksize,
   output logic [7:0]       pe_ifm_size,
   output logic             ofm_wr_req,
   input  logic             ofm_wr_ack,
   output logic [CNT_W-1:0] ofm_filt
);

   // Counters are 8 bit; larger layers cannot be walked.
   if (CI < 1 || CI > 255) begin : g_bad_ci
      $error("conv_layer_seq: CI must be in 1..255");
   end
   if (CO < 1 || CO > 255) begin : g_bad_co
      $error("conv_layer_seq: CO must be in 1..255");
   end
   if (TIMEOUT < 1 || TIMEOUT > 65536) begin : g_bad_timeout
      $error("conv_layer_seq: TIMEOUT must be in 1..65536");
   end

   localparam logic [CNT_W-1:0] CH_LAST   = CNT_W'(CI - 1);
   localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(CO - 1);
   // err is registered, so the abort decision is taken one count early to
   // land err exactly TIMEOUT+1 cycles after pe_start.
   localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(TIMEOUT - 1);

   conv_seq_state_t  state;
   logic [CNT_W-1:0] ch;
   logic [CNT_W-1:0] filt;
   logic [WD_W-1:0]  wd;
   logic             err_r;

   // Sequencer FSM: state, loop counters, watchdog and the err pulse.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // right-hand side sees the pre-edge value regardless of statement order.
   always_ff @(posedge clk1) begin
      if (rst) begin
         state <= S_IDLE;
         ch    <= '0;
         filt  <= '0;
         wd    <= '0;
         err_r <= 1'b0;
      end else begin
         err_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  ch    <= '0;
                  filt  <= '0;
                  state <= S_WREQ;
               end
            end
            S_WREQ: begin
               if (wgt_ack) state <= S_PE_GO;
            end
            S_PE_GO: begin
               wd    <= '0;
               state <= S_PE_WAIT;
            end
            S_PE_WAIT: begin
               if (pe_done) begin
                  if (ch < CH_LAST) begin
                     ch    <= ch + 1'b1;
                     state <= S_WREQ;
                  end else begin
                     state <= S_OFM_WR;
                  end
               end else if (wd == WD_LIMIT) begin
                  err_r <= 1'b1;
                  state <= S_IDLE;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            S_OFM_WR: begin
               if (ofm_wr_ack) begin
                  if (filt < FILT_LAST) begin
                     filt  <= filt + 1'b1;
                     ch    <= '0;
                     state <= S_WREQ;
                  end else begin
                     state <= S_FIN;
                  end
               end
            end
            S_FIN: begin
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Moore outputs decoded purely from registered state: no input-to-output path.
   assign busy        = (state != S_IDLE);
   assign done        = (state == S_FIN);
   assign err         = err_r;
   assign wgt_req     = (state == S_WREQ);
   assign pe_start    = (state == S_PE_GO);
   assign ofm_wr_req  = (state == S_OFM_WR);
   assign wgt_ch      = ch;
   assign wgt_filt    = filt;
   assign ofm_filt    = filt;
   // Gated by busy so both flags read 0 while idle and after reset.
   assign psum_clr    = busy && (ch == '0);
   assign psum_last   = busy && (ch == CH_LAST);
   assign pe_ksize    = 8'(KERNEL_SIZE);
   assign pe_ifm_size = 8'(IFM_SIZE);

endmodule
